pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). Each cycle it decides whether the PC and each pipeline register advances, holds or is flushed. It covers load-use hazards, taken branches and JAL resolved in EX, and a data-memory request/acknowledge handshake with a timeout watchdog. It also keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, default 8: maximum consecutive unacknowledged memory-wait cycles before fault; legal range 1..255.
- CNT_W, default 32: width of the performance counters.

- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load (LB/LH/LW/LBU/LHU).
- ex_branch_taken  in  1  EX resolved a taken B-type branch, or the EX instruction is JAL.
- mem_req  in  1  MEM-stage instruction is a load or store, with the request presented to data memory.
- mem_ack  in  1  data memory completes the request this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load bubble into ID/EX (all control bits 0).
- pipe_hold  out  1  hold ID/EX and EX/MEM contents.
- mem_wb_flush  out  1  load bubble into MEM/WB.
- mem_fault  out  1  sticky watchdog fault.
- stall_cycles  out  CNT_W  cycles with pc_write=0, saturating.
- flush_count  out  CNT_W  branch/JAL flush events, saturating.

## Operation
- Internal signals:
  - freeze = (mem_req & ~mem_ack) | (state==FAULT).
  - load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Outputs follow a fixed priority. Any condition not listed leaves its output at the RUN default: pc_write=1, if_id_write=1, all flush/hold outputs 0.
  1. freeze: pc_write=0, if_id_write=0, pipe_hold=1, mem_wb_flush=1, if_id_flush=0, id_ex_flush=0.
  2. ex_branch_taken: pc_write=1 so the redirect target loads, if_id_flush=1, id_ex_flush=1.
  3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1, giving exactly one bubble.
- If freeze and ex_branch_taken occur together, the flush is deferred. EX is held, so ex_branch_taken stays asserted and the flush fires in the cycle mem_ack arrives.
- A write to x0 never causes a load-use stall.
- FSM states: RUN, MEM_WAIT, FAULT; wait_cnt is 8 bits.
  - RUN: if mem_req & ~mem_ack, go to MEM_WAIT with wait_cnt=1. Otherwise stay in RUN.
  - MEM_WAIT: if mem_ack or ~mem_req, go to RUN with wait_cnt=0. A dropped mem_req without an acknowledge counts as an abort. Else, if wait_cnt==MEM_TIMEOUT, go to FAULT. Else increment wait_cnt.
  - FAULT: absorbing state. mem_fault=1 and freeze is permanent; mem_ack is ignored. Only reset leaves it.
- Counters:
  - stall_cycles increments in every cycle with pc_write=0, including FAULT.
  - flush_count increments in every cycle where priority 2 is applied.
  - Both counters saturate at 2^CNT_W-1.

## Timing
- All outputs are combinational from the current state and current inputs and are valid in the same cycle. State and counters are registered.
- Load-use costs exactly 1 stall cycle. A taken branch or JAL costs 2 flushed slots (IF/ID and ID/EX) in the same cycle.
- Watchdog timing: with mem_req high and mem_ack low from cycle 0, mem_fault rises at the start of cycle MEM_TIMEOUT+1.
- If mem_ack arrives in cycle MEM_TIMEOUT, the pipeline releases and no fault occurs.
- While reset is asserted, independent of clk:
  - state=RUN, wait_cnt=0, counters=0, mem_fault=0.
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0, mem_wb_flush=1.
- Asserting reset mid-wait or in FAULT aborts immediately. On the first edge after reset deasserts, the block is in RUN.

## Test plan
- Load-use: LW x5 in EX (ex_mem_read=1, ex_rd=5) with ADD x6,x5,x1 in ID.
  - Required: 1 cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1.
  - Repeat with ex_rd=0: no stall.
- Branch: ex_branch_taken=1 for 1 cycle -> pc_write=1, if_id_flush=1, id_ex_flush=1 that cycle; flush_count=1. Assert load_use in the same cycle -> branch response still wins.
- Memory wait: mem_req=1 with mem_ack low for 3 cycles, then high.
  - Required: freeze outputs for 3 cycles, then RUN; stall_cycles=3.
  - Assert ex_branch_taken=1 throughout -> the flush occurs only in the mem_ack cycle, and flush_count increments once.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ack=0 indefinitely.
  - Required: mem_fault=1 from cycle 5 and it stays high; a later mem_ack=1 has no effect.
  - A reset pulse clears mem_fault, the state and both counters.
- Saturation: CNT_W=4, hold freeze for 20 cycles -> stall_cycles stops at 15.
- Reset mid-wait: assert reset in MEM_WAIT with wait_cnt=2.
  - Required: outputs switch to reset values immediately, without a clock edge.
  - After release, a new mem_req stall restarts wait_cnt at 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard sources in, per-stage enables,
// flush/hold controls and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pipe_hold;
  logic             mem_wb_flush;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ack,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
           mem_wb_flush, mem_fault, stall_cycles, flush_count
  );

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ack,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
           mem_wb_flush, mem_fault, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage RV32I pipeline: load-use, EX-resolved
// redirects, data-memory wait with watchdog, and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FAULT    = 2'd2;
  localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic wait_pend, freeze, load_use, br_apply;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_wb_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign wait_pend = hz.mem_req & ~hz.mem_ack;
  assign freeze    = wait_pend | (state_q == FAULT);
  assign load_use  = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                     ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                      (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
  // A redirect under freeze is deferred: EX is held so the request persists.
  assign br_apply  = ~reset & ~freeze & hz.ex_branch_taken;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_hold    = 1'b0;
    mem_wb_flush = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      pipe_hold    = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (hz.ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (wait_pend) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        // Dropping mem_req without an ack is an abort, not a completion.
        if (hz.mem_ack || !hz.mem_req) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT) begin
          state_d    = FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      FAULT:   state_d = FAULT;
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  assign stall_d = pc_write ? stall_q : sat_inc(stall_q);
  assign flush_d = br_apply ? sat_inc(flush_q) : flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.pipe_hold    = pipe_hold;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.mem_fault    = (state_q == FAULT);
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// expected outputs produced by a behavioural model and checked by a monitor.
module tb_pipe_hazard_ctrl;
  localparam int T   = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .hz(bus));

  typedef struct {
    bit pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_wb_flush, mem_fault;
    int stall, flush;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: number of consecutive unacknowledged wait cycles, fault flag, counters.
  int m_waited = 0;
  bit m_fault  = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("pc_write",     bus.pc_write,     e.pc_write);
        chk("if_id_write",  bus.if_id_write,  e.if_id_write);
        chk("if_id_flush",  bus.if_id_flush,  e.if_id_flush);
        chk("id_ex_flush",  bus.id_ex_flush,  e.id_ex_flush);
        chk("pipe_hold",    bus.pipe_hold,    e.pipe_hold);
        chk("mem_wb_flush", bus.mem_wb_flush, e.mem_wb_flush);
        chk("mem_fault",    bus.mem_fault,    e.mem_fault);
        chk("stall_cycles", bus.stall_cycles, e.stall);
        chk("flush_count",  bus.flush_count,  e.flush);
      end
    end
  end

  task automatic cycle(input bit rst, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit mr, input bit bt, input bit req, input bit ack);
    exp_t e;
    bit   frz, lu, br;
    reset               = rst;
    bus.id_rs1          = 5'(rs1);
    bus.id_rs2          = 5'(rs2);
    bus.id_uses_rs1     = u1;
    bus.id_uses_rs2     = u2;
    bus.ex_rd           = 5'(rd);
    bus.ex_mem_read     = mr;
    bus.ex_branch_taken = bt;
    bus.mem_req         = req;
    bus.mem_ack         = ack;
    br = 1'b0;
    if (rst) begin
      m_waited = 0; m_fault = 0; m_stall = 0; m_flush = 0;
      e = '{0, 0, 1, 1, 0, 1, 0, 0, 0};
    end else begin
      frz = m_fault || (req && !ack);
      lu  = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e = '{1, 1, 0, 0, 0, 0, m_fault, m_stall, m_flush};
      if (frz) begin
        e.pc_write = 0; e.if_id_write = 0; e.pipe_hold = 1; e.mem_wb_flush = 1;
      end else if (bt) begin
        e.if_id_flush = 1; e.id_ex_flush = 1; br = 1'b1;
      end else if (lu) begin
        e.pc_write = 0; e.if_id_write = 0; e.id_ex_flush = 1;
      end
    end
    sbq.push_back(e);
    @(posedge clk);
    if (!rst) begin
      if (!e.pc_write && m_stall < SAT) m_stall++;
      if (br && m_flush < SAT) m_flush++;
      if (!m_fault) begin
        if (req && !ack) begin
          if (m_waited == T) m_fault = 1;
          else m_waited++;
        end else begin
          m_waited = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic memwait(input bit bt, input bit ack);
    cycle(0, 0, 0, 0, 0, 0, 0, bt, 1, ack);
  endtask

  initial begin
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.ex_rd = '0; bus.ex_mem_read = 0; bus.ex_branch_taken = 0;
    bus.mem_req = 0; bus.mem_ack = 0;
    @(posedge clk); #1;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // LW x5 in EX, ADD x6,x5,x1 in ID; then the same with rd=x0.
    cycle(0, 5, 1, 1, 1, 5, 1, 0, 0, 0);
    idle();
    chk("lu_stall_count", bus.stall_cycles, 1);
    cycle(0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    chk("x0_no_stall", bus.stall_cycles, 1);

    // Branch alone, then branch colliding with a load-use.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("branch_flush_count", bus.flush_count, 1);
    cycle(0, 7, 2, 1, 1, 7, 1, 1, 0, 0);
    chk("branch_wins_flush", bus.flush_count, 2);
    chk("branch_wins_stall", bus.stall_cycles, 1);

    // Three wait cycles with a pending branch, then ack.
    repeat (3) memwait(1, 0);
    memwait(1, 1);
    idle();
    chk("memwait_stall", bus.stall_cycles, 4);
    chk("memwait_flush", bus.flush_count, 3);

    // Watchdog: fault rises at start of cycle T+1, ack ignored, stall saturates.
    repeat (T) memwait(0, 0);
    chk("no_fault_yet", bus.mem_fault, 0);
    memwait(0, 0);
    chk("fault_raised", bus.mem_fault, 1);
    repeat (2) memwait(0, 1);
    repeat (20) idle();
    chk("fault_sticky", bus.mem_fault, 1);
    chk("stall_saturated", bus.stall_cycles, SAT);

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("reset_clears_fault", bus.mem_fault, 0);

    // Ack arriving exactly at wait count T releases without fault.
    repeat (T) memwait(0, 0);
    memwait(0, 1);
    idle();
    chk("late_ack_no_fault", bus.mem_fault, 0);

    // Reset mid-wait with wait count 2: outputs must change before any edge.
    repeat (2) memwait(0, 0);
    reset = 1'b1;
    #2;
    chk("async_pc_write",    bus.pc_write, 0);
    chk("async_if_id_flush", bus.if_id_flush, 1);
    chk("async_pipe_hold",   bus.pipe_hold, 0);
    chk("async_stall_clr",   bus.stall_cycles, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (T + 1) memwait(0, 0);
    chk("restart_fault_timing", bus.mem_fault, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 39) == 0),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0));
    end

    for (int k = 0; k < 10 && sbq.size() != 0; k++) @(posedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
